// File: rtl/ula_multiciclo.sv
// Multi-cycle signed ALU. Single-cycle ops finish one cycle after the
// start is sampled. MUL and DIV iterate DATA_WIDTH cycles over operand
// magnitudes, then apply the result sign at the end.
module ula_multiciclo #(
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 4,
  parameter logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(0),
  parameter logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(1),
  parameter logic [OPCODE_WIDTH-1:0] OP_MUL = OPCODE_WIDTH'(2),
  parameter logic [OPCODE_WIDTH-1:0] OP_DIV = OPCODE_WIDTH'(3),
  parameter logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(4),
  parameter logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(5),
  parameter logic [OPCODE_WIDTH-1:0] OP_NOT = OPCODE_WIDTH'(6),
  parameter logic [OPCODE_WIDTH-1:0] OP_CMP = OPCODE_WIDTH'(7)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [OPCODE_WIDTH-1:0] opcode,
  input  logic [DATA_WIDTH-1:0]   data1,
  input  logic [DATA_WIDTH-1:0]   data2,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   out,
  output logic [4:0]              rflags
);
  localparam int W = DATA_WIDTH;

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, FIN = 2'd2} state_t;

  state_t                  state;
  logic [OPCODE_WIDTH-1:0] op_r;
  logic                    neg_r;   // sign of the MUL/DIV result
  logic [W-1:0]            b_r;     // divisor as latched
  logic [W-1:0]            cnt;
  logic [W-1:0]            mq;      // MUL: multiplier bits; DIV: dividend in, quotient out
  logic [W-1:0]            rem;
  logic [2*W-1:0]          acc;
  logic [2*W-1:0]          mc_sh;   // multiplicand shifted by iteration count

  logic [W-1:0] mag1, mag2, sum, diff, s_out;
  logic [4:0]   s_flags;
  logic         add_ovf, sub_ovf, gt, eq, lt, go_iter;

  logic [W-1:0]   b_mag, rem_nx, q_nx, quot;
  logic [W:0]     rem_sh;
  logic           rem_ge, mul_ovf, div_ovf;
  logic [2*W-1:0] acc_nx, prod;

  // Operand decode for ops that finish without iterating
  always_comb begin
    mag1    = data1[W-1] ? (~data1 + 1'b1) : data1;
    mag2    = data2[W-1] ? (~data2 + 1'b1) : data2;
    sum     = data1 + data2;
    diff    = data1 - data2;
    add_ovf = (data1[W-1] == data2[W-1]) && (sum[W-1] != data1[W-1]);
    sub_ovf = (data1[W-1] != data2[W-1]) && (diff[W-1] != data1[W-1]);
    gt      = $signed(data1) > $signed(data2);
    eq      = data1 == data2;
    lt      = $signed(data1) < $signed(data2);
    go_iter = (opcode == OP_MUL) || ((opcode == OP_DIV) && (data2 != '0));
  end

  // Single-cycle result; DIV only lands here when dividing by zero
  always_comb begin
    s_out   = '0;
    s_flags = '0;
    case (opcode)
      OP_ADD: begin s_out = sum;  s_flags[4] = add_ovf; end
      OP_SUB: begin s_out = diff; s_flags[4] = sub_ovf; end
      OP_CMP: begin s_out = diff; s_flags = {sub_ovf, gt, eq, lt, 1'b0}; end
      OP_DIV: s_flags = 5'b00001;
      OP_AND: s_out = data1 & data2;
      OP_OR:  s_out = data1 | data2;
      OP_NOT: s_out = {{(W-1){1'b0}}, (data1 == '0)};
      default: ;
    endcase
  end

  // One shift-add / restoring-divide step plus sign fix-up of the final step
  always_comb begin
    b_mag   = b_r[W-1] ? (~b_r + 1'b1) : b_r;
    acc_nx  = acc + (mq[0] ? mc_sh : '0);
    rem_sh  = {rem, mq[W-1]};
    rem_ge  = rem_sh >= {1'b0, b_mag};
    rem_nx  = rem_ge ? (rem_sh[W-1:0] - b_mag) : rem_sh[W-1:0];
    q_nx    = {mq[W-2:0], rem_ge};
    prod    = neg_r ? (~acc_nx + 1'b1) : acc_nx;
    mul_ovf = !((&prod[2*W-1:W-1]) || !(|prod[2*W-1:W-1]));
    quot    = neg_r ? (~q_nx + 1'b1) : q_nx;
    div_ovf = !neg_r && q_nx[W-1];
  end

  // Control FSM with registered busy/done/out/rflags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      out    <= '0;
      rflags <= '0;
      op_r   <= '0;
      neg_r  <= 1'b0;
      b_r    <= '0;
      cnt    <= '0;
      mq     <= '0;
      rem    <= '0;
      acc    <= '0;
      mc_sh  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          op_r  <= opcode;
          neg_r <= data1[W-1] ^ data2[W-1];
          b_r   <= data2;
          cnt   <= '0;
          acc   <= '0;
          rem   <= '0;
          mc_sh <= {{W{1'b0}}, mag1};
          mq    <= (opcode == OP_MUL) ? mag2 : mag1;
          busy  <= 1'b1;
          if (go_iter) begin
            state <= ITER;
          end else begin
            out    <= s_out;
            rflags <= s_flags;
            done   <= 1'b1;
            state  <= FIN;
          end
        end
        ITER: begin
          cnt <= cnt + 1'b1;
          if (op_r == OP_MUL) begin
            acc   <= acc_nx;
            mc_sh <= mc_sh << 1;
            mq    <= mq >> 1;
          end else begin
            rem <= rem_nx;
            mq  <= q_nx;
          end
          if (cnt == W'(W-1)) begin
            state  <= FIN;
            done   <= 1'b1;
            out    <= (op_r == OP_MUL) ? prod[W-1:0] : quot;
            rflags <= {((op_r == OP_MUL) ? mul_ovf : div_ovf), 4'b0000};
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ula_multiciclo.sv
// Directed bench for ula_multiciclo (DATA_WIDTH=16). An arithmetic model
// tracks busy/done/out/rflags every cycle; directed vectors carry literal
// expected results and latencies.
module tb_ula_multiciclo;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3,
                         OP_AND = 4'd4, OP_OR = 4'd5, OP_NOT = 4'd6, OP_CMP = 4'd7;

  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [3:0]  opcode;
  logic [15:0] data1, data2, out;
  logic        busy, done;
  logic [4:0]  rflags;

  int tests = 0;
  int fails = 0;

  ula_multiciclo #(.DATA_WIDTH(16), .OPCODE_WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .data1(data1), .data2(data2), .busy(busy), .done(done),
    .out(out), .rflags(rflags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of an op from plain signed integer arithmetic
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] o, output logic [4:0] f, output int lat);
    int sa, sb, r;
    sa = $signed(a);
    sb = $signed(b);
    r = 0; o = '0; f = '0; lat = 1;
    case (op)
      OP_ADD: begin r = sa + sb; o = r[15:0]; f[4] = (r > 32767) || (r < -32768); end
      OP_SUB: begin r = sa - sb; o = r[15:0]; f[4] = (r > 32767) || (r < -32768); end
      OP_CMP: begin
        r = sa - sb; o = r[15:0]; f[4] = (r > 32767) || (r < -32768);
        f[3] = sa > sb; f[2] = sa == sb; f[1] = sa < sb;
      end
      OP_MUL: begin r = sa * sb; o = r[15:0]; f[4] = (r > 32767) || (r < -32768); lat = 17; end
      OP_DIV: begin
        if (sb == 0) f = 5'b00001;
        else begin r = sa / sb; o = r[15:0]; f[4] = r > 32767; lat = 17; end
      end
      OP_AND: o = a & b;
      OP_OR:  o = a | b;
      OP_NOT: o = (a == 16'h0) ? 16'h1 : 16'h0;
      default: ;
    endcase
  endfunction

  // Cycle tracker: acceptance, busy window, done pulse and held result
  int          cyc = 0;
  int          m_end = -1;
  int          m_done = -1;
  int          m_lat;
  logic [15:0] m_out = '0, p_out;
  logic [4:0]  m_fl = '0, p_fl;

  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_end = cyc - 1; m_done = -1; m_out = '0; m_fl = '0;
    end else if (start && (cyc - 1 > m_end)) begin
      model(opcode, data1, data2, p_out, p_fl, m_lat);
      m_end  = cyc + m_lat - 1;
      m_done = m_end;
    end
    #1;
    if (cyc == m_done) begin m_out = p_out; m_fl = p_fl; end
    chk("busy", busy, cyc <= m_end);
    chk("done", done, cyc == m_done);
    chk("out", out, m_out);
    chk("rflags", rflags, m_fl);
  end

  // Called at a negedge; ends at the negedge before the post-done edge
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] xo, input logic [4:0] xf, input int xlat,
                        input bit pulse_busy);
    int k;
    bit got;
    start = 1'b1; opcode = op; data1 = a; data2 = b;
    @(posedge clk);
    k = 1;
    #1 got = done;
    while (!got && k < 40) begin
      @(negedge clk);
      start  = pulse_busy ? k[0] : 1'b0;
      opcode = 4'($urandom_range(0, 15));
      data1  = 16'($urandom);
      data2  = 16'($urandom);
      @(posedge clk);
      #1;
      k++;
      got = done;
    end
    chk("latency", k, xlat);
    chk("vec_out", out, xo);
    chk("vec_rflags", rflags, xf);
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; opcode = '0; data1 = '0; data2 = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 5'b10000, 1, 0);
    @(negedge clk); run_op(OP_ADD, 16'h0003, 16'h0004, 16'h0007, 5'b00000, 1, 0);
    @(negedge clk); run_op(OP_SUB, 16'h8000, 16'h0001, 16'h7FFF, 5'b10000, 1, 0);
    @(negedge clk); run_op(OP_MUL, 16'hFFFD, 16'h0007, 16'hFFEB, 5'b00000, 17, 1);
    @(negedge clk); run_op(OP_MUL, 16'd300, 16'd300, 16'h5F90, 5'b10000, 17, 0);
    @(negedge clk); run_op(OP_MUL, 16'h8000, 16'hFFFF, 16'h8000, 5'b10000, 17, 1);
    @(negedge clk); run_op(OP_MUL, 16'h0000, 16'h1234, 16'h0000, 5'b00000, 17, 0);
    @(negedge clk); run_op(OP_DIV, 16'hFFF9, 16'h0002, 16'hFFFD, 5'b00000, 17, 1);
    @(negedge clk); run_op(OP_DIV, 16'h0005, 16'h0000, 16'h0000, 5'b00001, 1, 0);
    @(negedge clk); run_op(OP_DIV, 16'h8000, 16'hFFFF, 16'h8000, 5'b10000, 17, 0);
    @(negedge clk); run_op(OP_DIV, 16'd100, 16'hFFF9, 16'hFFF2, 5'b00000, 17, 0);
    @(negedge clk); run_op(OP_CMP, 16'h8000, 16'h0001, 16'h7FFF, 5'b10010, 1, 0);
    @(negedge clk); run_op(OP_CMP, 16'h0005, 16'h0005, 16'h0000, 5'b00100, 1, 0);
    @(negedge clk); run_op(OP_CMP, 16'h7FFF, 16'hFFFF, 16'h8000, 5'b11000, 1, 0);
    @(negedge clk); run_op(OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 5'b00000, 1, 0);
    @(negedge clk); run_op(OP_OR,  16'hF0F0, 16'h3C3C, 16'hFCFC, 5'b00000, 1, 0);
    @(negedge clk); run_op(4'hF,   16'h1234, 16'h5678, 16'h0000, 5'b00000, 1, 0);
    @(negedge clk); run_op(OP_NOT, 16'h0000, 16'h9999, 16'h0001, 5'b00000, 1, 0);
    @(negedge clk); run_op(OP_NOT, 16'h0005, 16'h0000, 16'h0000, 5'b00000, 1, 0);
    @(negedge clk); run_op(OP_MUL, 16'h0003, 16'h0005, 16'h000F, 5'b00000, 17, 0);

    // Abort a MUL with reset at T+5
    @(negedge clk);
    start = 1'b1; opcode = OP_MUL; data1 = 16'h0123; data2 = 16'h0045;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_out", out, 16'h0000);
    chk("rst_rflags", rflags, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (20) begin
      @(posedge clk);
      #1 if (done) ndone++;
    end
    chk("no_done_after_abort", ndone, 0);
    @(negedge clk); run_op(OP_SUB, 16'h0002, 16'h0005, 16'hFFFD, 5'b00000, 1, 0);
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1);
  end
endmodule
